// File: rtl/banda_result_collector.sv
// ---------------------------------------------------------------------------
// banda_result_collector
//
// Reader end of the assembly-line pipeline.  The serial single-bit pipeline
// result f is sampled on load-qualified edges, but only when the valid tag
// that travelled alongside the tuple says the slot holds real data.  Captured
// bits are packed LSB-first into WIDTH-bit words.  Finished words are handed
// to a one-entry valid/ready output register.  A word that completes while
// that register is still occupied and not being drained is dropped, and the
// sticky overflow flag is raised.
//
// Parameters
//   WIDTH    bits per assembled output word (2..32)
//   LATENCY  load-gated register stages between pipeline input and f (1..8)
//
// Ports
//   clk        system clock, rising edge
//   clear      asynchronous active-low reset
//   load       pipeline advance strobe (same enable as the pipeline registers)
//   in_valid   tuple entering the pipeline on this load edge is real data
//   f          pipeline result bit (output of the final pipeline register)
//   out_ready  downstream accepts out_data
//   out_data   assembled word, LSB = earliest result
//   out_valid  out_data holds an unconsumed word
//   overflow   sticky: a completed word was dropped
//   bit_cnt    bits collected toward the current word
//   out_parity XOR of the word held in out_data (only with BANDA_PARITY_EN)
//
// Build option
//   BANDA_PARITY_EN  when defined, adds the registered out_parity output.
// ---------------------------------------------------------------------------
module banda_result_collector #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 4,
   localparam int CNT_W  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             in_valid,
   input  logic             f,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             overflow,
   output logic [CNT_W-1:0] bit_cnt
`ifdef BANDA_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [LATENCY-1:0] tag_q, tag_d;
   logic [WIDTH-1:0]   shift_q;
   logic [WIDTH-1:0]   word_w;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               overflow_q, overflow_d;
   logic               capture;
   logic               complete;

   // The tag pipe mirrors the data pipeline: a tuple's valid bit reaches
   // the top of the pipe exactly when its result is present on f.
   assign tag_d[0] = in_valid;
   for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
      assign tag_d[gi] = tag_q[gi-1];
   end

   assign capture  = load & tag_q[LATENCY-1];
   assign complete = capture && (bit_cnt_q == CNT_W'(WIDTH - 1));

   // Current word with f merged at the write position.  This is both the
   // shift register's next value and, on completion, the finished word,
   // so the last bit never costs an extra cycle.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_word
      assign word_w[gi] = (bit_cnt_q == CNT_W'(gi)) ? f : shift_q[gi];
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (capture) begin
         bit_cnt_d = complete ? '0 : bit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         tag_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (load) begin
         tag_q     <= tag_d;
         bit_cnt_q <= bit_cnt_d;
         if (capture) begin
            shift_q <= word_w;
         end
      end
   end

   // Output holding register FSM.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      overflow_d = overflow_q;
      case (state_q)
         EMPTY: begin
            if (complete) begin
               out_data_d = word_w;
               state_d    = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               // Draining and refilling on the same edge keeps FULL.
               if (complete) begin
                  out_data_d = word_w;
               end else begin
                  state_d = EMPTY;
               end
            end else if (complete) begin
               overflow_d = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q    <= EMPTY;
         out_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         overflow_q <= overflow_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = (state_q == FULL);
   assign overflow  = overflow_q;
   assign bit_cnt   = bit_cnt_q;

`ifdef BANDA_PARITY_EN
   logic parity_q, parity_d;

   // Parity follows out_data: it is recomputed only when a word is loaded.
   always_comb begin
      parity_d = parity_q;
      if (complete && (state_q == EMPTY || out_ready)) begin
         parity_d = ^word_w;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_banda_result_collector.sv
module tb_banda_result_collector;

   localparam int WIDTH = 8;
   localparam int LAT   = 4;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             clear = 1'b0;
   logic             load = 1'b0;
   logic             in_valid = 1'b0;
   logic             f = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             overflow;
   logic [CW-1:0]    bit_cnt;
`ifdef BANDA_PARITY_EN
   logic             out_parity;
`endif

   banda_result_collector #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .clear     (clear),
      .load      (load),
      .in_valid  (in_valid),
      .f         (f),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .overflow  (overflow),
      .bit_cnt   (bit_cnt)
`ifdef BANDA_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Load edges are numbered since reset; hist[k] is the in_valid seen at
   // load edge k.  The result on f at edge k belongs to edge k-LAT.
   int               k;
   int               base;
   bit               hist[0:8191];
   bit               bits_q[$];   // results collected toward current word
   bit               want_q[$];   // bits the bench wants captured next
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   bit               m_ovf;
   bit               m_par;

   function automatic bit cap_now(input bit ld);
      return ld && (k - base >= LAT) && hist[k - LAT];
   endfunction

   task automatic model_reset();
      base = k;
      bits_q.delete();
      want_q.delete();
      m_valid = 0;
      m_data  = '0;
      m_ovf   = 0;
      m_par   = 0;
   endtask

   task automatic check_all(input string where);
      check({where, ".valid"},  32'(out_valid), 32'(m_valid));
      check({where, ".data"},   32'(out_data),  32'(m_data));
      check({where, ".ovf"},    32'(overflow),  32'(m_ovf));
      check({where, ".bitcnt"}, 32'(bit_cnt),   32'(bits_q.size()));
`ifdef BANDA_PARITY_EN
      check({where, ".parity"}, 32'(out_parity), 32'(m_par));
`endif
   endtask

   task automatic step(input bit ld, input bit iv, input bit rdy);
      bit               c;
      bit               done;
      logic [WIDTH-1:0] word;
      @(negedge clk);
      load      = ld;
      in_valid  = iv;
      out_ready = rdy;
      c = cap_now(ld);
      if (c && want_q.size() > 0) f = want_q.pop_front();
      else                        f = 1'($urandom);
      @(posedge clk);
      done = 0;
      word = '0;
      if (ld) begin
         if (c) bits_q.push_back(f);
         hist[k] = iv;
         k++;
         if (bits_q.size() == WIDTH) begin
            done = 1;
            for (int i = 0; i < WIDTH; i++) word[i] = bits_q[i];
            bits_q.delete();
         end
      end
      if (m_valid && rdy) begin
         if (done) begin m_data = word; m_par = ^word; end
         else m_valid = 0;
      end else if (m_valid && done) begin
         m_ovf = 1;
      end else if (done) begin
         m_data  = word;
         m_par   = ^word;
         m_valid = 1;
      end
      #1;
      check_all("step");
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = 0; i < WIDTH; i++) want_q.push_back(w[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear    = 1'b0;
      load     = 1'($urandom);
      in_valid = 1'($urandom);
      f        = 1'($urandom);
      #1;
      model_reset();
      check_all("reset_async");
      @(negedge clk);
      clear = 1'b1;
   endtask

   initial begin
      k = 0;
      model_reset();

      // Reset held with random inputs while the clock runs.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         load      = 1'($urandom);
         in_valid  = 1'($urandom);
         f         = 1'($urandom);
         out_ready = 1'($urandom);
         #1;
         check_all("reset_hold");
      end
      @(negedge clk);
      clear = 1'b1;

      // Basic word: 8 valid tuples then 4 flush loads.
      push_word(8'h4D);
      for (int i = 0; i < 12; i++) begin
         step(1, i < 8, 0);
         if (i == 10) check("basic.early", 32'(out_valid), 32'd0);
      end
      check("basic.valid", 32'(out_valid), 32'd1);
      check("basic.data",  32'(out_data),  32'h4D);
`ifdef BANDA_PARITY_EN
      check("basic.parity", 32'(out_parity), 32'd0);
`endif
      step(0, 0, 1);
      check("basic.drain", 32'(out_valid), 32'd0);

      // Bubbles: alternating valid slots, only those carry ones.
      push_word(8'hFF);
      for (int i = 0; i < 20; i++) step(1, (i < 16) && (i % 2 == 0), 0);
      check("bubble.data", 32'(out_data), 32'hFF);
      step(0, 0, 1);

      // Load gating mid-word.
      push_word(8'hA6);
      for (int i = 0; i < 6; i++) step(1, 1, 0);
      for (int i = 0; i < 10; i++) step(0, 1'($urandom), 0);
      check("gate.bitcnt", 32'(bit_cnt), 32'd2);
      for (int i = 0; i < 6; i++) step(1, i < 2, 0);
      check("gate.data", 32'(out_data), 32'hA6);
      step(0, 0, 1);

      // Simultaneous accept and completion.
      push_word(8'h4D);
      push_word(8'hB2);
      for (int i = 0; i < 20; i++) step(1, i < 16, i == 19);
      check("simul.valid", 32'(out_valid), 32'd1);
      check("simul.data",  32'(out_data),  32'hB2);
      check("simul.ovf",   32'(overflow),  32'd0);
      step(0, 0, 1);

      // Backpressure: second word is dropped.
      push_word(8'h4D);
      push_word(8'hB2);
      for (int i = 0; i < 20; i++) step(1, i < 16, 0);
      check("bp.ovf",  32'(overflow), 32'd1);
      check("bp.data", 32'(out_data), 32'h4D);
      step(0, 0, 1);
      check("bp.drain", 32'(out_valid), 32'd0);

      // Reset in the middle of a word.
      do_reset();
      push_word(8'hFF);
      for (int i = 0; i < 9; i++) step(1, 1, 0);
      check("midrst.bitcnt", 32'(bit_cnt), 32'd5);
      do_reset();
      push_word(8'h3C);
      for (int i = 0; i < 12; i++) step(1, i < 8, 0);
      check("midrst.data", 32'(out_data), 32'h3C);
      step(0, 0, 1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(2) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/banda_result_collector.md
Name: banda_result_collector

Overview:
- Reader end of the assembly-line pipeline. It consumes the pipeline's serial single-bit result f, load-qualified, and packs the results into WIDTH-bit words.
- It tracks pipeline latency with a valid-tag shift register, so bubbles (load edges with no valid tuple) are skipped.
- Completed words are presented on a valid/ready output port with one holding register and a sticky overflow flag.
- Sits directly after the pipeline's final register and shares its clk and load.

Parameters:
- WIDTH, 8, bits per assembled output word (2..32)
- LATENCY, 4, number of load-gated register stages between pipeline input and f (1..8)

Ports:
- clk  input  1  system clock, rising edge
- clear  input  1  asynchronous active-low reset
- load  input  1  pipeline advance strobe; the same signal that enables the pipeline registers
- in_valid  input  1  tuple presented to the pipeline on this load edge is real data
- f  input  1  pipeline result bit (output of the final pipeline register)
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  assembled word, LSB = earliest result
- out_valid  output  1  out_data holds an unconsumed word
- overflow  output  1  sticky: a completed word was dropped
- bit_cnt  output  $clog2(WIDTH+1)  bits collected toward the current word

Behaviour:
- Reset (clear=0, asynchronous): tag, shift register, bit_cnt, out_data, out_valid and overflow all go to 0. The state machine goes to EMPTY. Reset is honoured mid-word and mid-hold; any partial word is discarded.
- Tag pipe:
  - On each rising edge with load=1: tag[0] <= in_valid and tag[i] <= tag[i-1].
  - With load=0, tag, shift register and bit_cnt hold.
- Capture:
  - On a rising edge with load=1 and tag[LATENCY-1]=1: shift_reg[bit_cnt] <= f and bit_cnt++.
  - A tuple loaded at load edge k is captured at load edge k+LATENCY.
  - Tag advance and capture happen on the same edge.
- Word completion:
  - When a capture brings bit_cnt to WIDTH, the word goes to the holding register and bit_cnt returns to 0 on that same edge. There is no dead cycle, so the next capture can occur on the following load edge.
- Output FSM, two states:
  - EMPTY (out_valid=0): on word completion, out_data <= word and go to FULL.
  - FULL (out_valid=1):
    - out_ready=1 and no completion: go to EMPTY; out_data holds its last value.
    - out_ready=1 and completion on the same edge: load the new word and stay FULL. No overflow.
    - out_ready=0 and completion: drop the new word, keep the old out_data, set overflow=1. overflow stays set until reset.
  - The handshake is consumed only when out_valid=1 and out_ready=1. out_ready is ignored in EMPTY.
- Timing: out_data and out_valid are registered; no combinational path from any input to any output. out_data is stable while out_valid=1 and out_ready=0.
- Flushing: results still in flight are collected only when load keeps pulsing. The driver flushes with load=1 and in_valid=0 for LATENCY edges.
- Simultaneous events:
  - in_valid has no effect while load=0.
  - Capture plus out_ready in the same cycle is handled as stated in the FSM rules above.

Optional Feature:
- Macro: BANDA_PARITY_EN
- Defined: adds output port out_parity (1 bit), registered alongside out_data, equal to the XOR of all bits of the word loaded. Reset value 0.
- Undefined: no out_parity port and no parity logic. All other behaviour is identical.

Test Plan:
- Reset: clear=0 with random inputs -> out_valid=0, out_data=0, overflow=0, bit_cnt=0. These values hold while clear=0 regardless of clk.
- Basic word (WIDTH=8, LATENCY=4): 8 consecutive load edges with in_valid=1 and f arriving as 1,0,1,1,0,0,1,0, followed by 4 flush loads -> out_valid rises after the 12th load edge with out_data=8'h4D. With the macro defined, out_parity=0.
- Bubbles: in_valid pattern 1,0,1,0,... over 16 loads with f=1 on valid slots only -> 8'hFF after the tuple loaded at load edge 15 is captured; bubble slots are never captured.
- Load gating: load held 0 for 10 cycles mid-word -> bit_cnt, tags and outputs unchanged. Resuming load continues the word correctly.
- Backpressure: out_ready=0, two words completed (8'h4D then 8'hB2) -> overflow=1 and out_data stays 8'h4D. Then pulse out_ready=1 -> out_valid=0 next cycle.
- Simultaneous: second word completes on the same edge as the first is accepted (out_ready=1) -> out_valid stays 1, out_data=new word, overflow=0. Also assert clear=0 at bit_cnt=5, release, and send a full word -> the word contains only post-reset bits.
